sdfm_sinc_filter_p: RTL

- Parametrised single-channel sinc (CIC) decimation filter for the sigma-delta demodulator.
- Next generation of the per-channel data filter: selectable order 1..MAX_ORD, OSR up to 2^DEC_W, post-shift and output saturation.
- Adds a settling-discard counter, acknowledge-mode hold with overrun flag, and automatic restart on configuration change.
- Fed by the channel's input synchroniser (sample strobe plus bit). Outputs go to the register map.

---
 rtl/sdfm_sinc_filter_p.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sdfm_sinc_filter_p.sv
// Single-channel sinc1..sinc4 (CIC) decimation filter with settle discard,
// acknowledge-mode hold/overrun, post-shift, saturation and restart on config change.
module sdfm_sinc_filter_p #(
   parameter int unsigned DEC_W   = 8,
   parameter int unsigned MAX_ORD = 4,
   parameter int unsigned OUT_W   = 32,
   parameter int unsigned SH_W    = 5
) (
   input  logic             SYSCLK,
   input  logic             SYSRSTn,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             reg_filten,
   input  logic [1:0]       reg_filtst,
   input  logic [DEC_W-1:0] reg_filtdec,
   input  logic [SH_W-1:0]  reg_filtsh,
   input  logic             reg_filtask,
   input  logic             filt_ack,
   output logic [OUT_W-1:0] filt_data_out,
   output logic             filt_data_update,
   output logic             filt_pending,
   output logic             filt_ovr,
   output logic             filt_sat
);

   localparam int unsigned ACC_W = MAX_ORD * DEC_W + 1;
   localparam int unsigned ORD_W = 3;
   localparam int unsigned EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

   logic [ACC_W-1:0] integ_q [MAX_ORD];
   logic [ACC_W-1:0] integ_d [MAX_ORD];
   logic [ACC_W-1:0] dly_q   [MAX_ORD];
   logic [ACC_W-1:0] dly_d   [MAX_ORD];
   logic [ACC_W-1:0] stg     [MAX_ORD+1];
   logic [DEC_W-1:0] cnt_q, cnt_d, dec_q;
   logic [ORD_W-1:0] settle_q, settle_d, ord, ord_raw;
   logic [1:0]       st_q;
   logic [SH_W-1:0]  sh_q;
   logic             evt_q, evt_d;
   logic [OUT_W-1:0] data_q, data_d;
   logic             upd_q, upd_d, pend_q, pend_d, ovr_q, ovr_d, sat_q, sat_d;
   logic             cfg_chg, discard, res_ok, accept, sat_w;
   logic [ACC_W-1:0] c_in, res;
   logic [EXT_W-1:0] r_ext;

   // Datapath and control next-state
   always_comb begin
      cfg_chg = (reg_filtst != st_q) || (reg_filtdec != dec_q) || (reg_filtsh != sh_q);
      ord_raw = {1'b0, st_q} + 3'd1;
      ord     = (ord_raw > ORD_W'(MAX_ORD)) ? ORD_W'(MAX_ORD) : ord_raw;

      // Integrators use registered upstream values (pipelined chain)
      integ_d = integ_q;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
      if (bit_valid) begin
         integ_d[0] = integ_q[0] + ACC_W'(bit_in);
         for (int k = 1; k < int'(MAX_ORD); k++) begin
            if (ORD_W'(k) < ord) integ_d[k] = integ_q[k] + integ_q[k-1];
         end
         evt_d = (cnt_q == dec_q);
         cnt_d = (cnt_q == dec_q) ? '0 : cnt_q + DEC_W'(1);
      end

      c_in = integ_q[0];
      for (int k = 0; k < int'(MAX_ORD); k++) begin
         if (ORD_W'(k + 1) == ord) c_in = integ_q[k];
      end
      stg[0] = c_in;
      for (int k = 0; k < int'(MAX_ORD); k++) stg[k+1] = stg[k] - dly_q[k];
      res = stg[0];
      for (int k = 1; k <= int'(MAX_ORD); k++) begin
         if (ORD_W'(k) == ord) res = stg[k];
      end

      dly_d = dly_q;
      if (evt_q) begin
         for (int k = 0; k < int'(MAX_ORD); k++) begin
            if (ORD_W'(k) < ord) dly_d[k] = stg[k];
         end
      end

      r_ext = EXT_W'(res) >> sh_q;
      sat_w = |(r_ext >> OUT_W);

      discard  = evt_q && (settle_q < ord);
      settle_d = discard ? settle_q + 3'd1 : settle_q;
      res_ok   = evt_q && !discard && !cfg_chg && reg_filten;
      accept   = !reg_filtask || !pend_q || filt_ack;

      data_d = data_q;
      upd_d  = 1'b0;
      sat_d  = 1'b0;
      if (res_ok && accept) begin
         data_d = sat_w ? '1 : OUT_W'(r_ext);
         upd_d  = 1'b1;
         sat_d  = sat_w;
      end

      pend_d = pend_q;
      ovr_d  = ovr_q;
      if (!reg_filtask) begin
         pend_d = 1'b0;
         ovr_d  = 1'b0;
      end else begin
         if (res_ok && accept) pend_d = 1'b1;
         else if (filt_ack)    pend_d = 1'b0;
         if (filt_ack)                 ovr_d = 1'b0;
         else if (res_ok && pend_q)    ovr_d = 1'b1;
      end

      // Disable or configuration change restarts the filter state
      if (!reg_filten || cfg_chg) begin
         for (int k = 0; k < int'(MAX_ORD); k++) begin
            integ_d[k] = '0;
            dly_d[k]   = '0;
         end
         cnt_d    = '0;
         settle_d = '0;
         evt_d    = 1'b0;
      end
      if (!reg_filten) begin
         upd_d  = 1'b0;
         sat_d  = 1'b0;
         pend_d = 1'b0;
         ovr_d  = 1'b0;
      end
   end

   always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
      if (!SYSRSTn) begin
         for (int k = 0; k < int'(MAX_ORD); k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
         end
         cnt_q    <= '0;
         settle_q <= '0;
         evt_q    <= 1'b0;
         st_q     <= '0;
         dec_q    <= '0;
         sh_q     <= '0;
         data_q   <= '0;
         upd_q    <= 1'b0;
         pend_q   <= 1'b0;
         ovr_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         integ_q  <= integ_d;
         dly_q    <= dly_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         evt_q    <= evt_d;
         st_q     <= reg_filtst;
         dec_q    <= reg_filtdec;
         sh_q     <= reg_filtsh;
         data_q   <= data_d;
         upd_q    <= upd_d;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
         sat_q    <= sat_d;
      end
   end

   assign filt_data_out    = data_q;
   assign filt_data_update = upd_q;
   assign filt_pending     = pend_q;
   assign filt_ovr         = ovr_q;
   assign filt_sat         = sat_q;

endmodule
